// File: rtl/keccak_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// keccak_arbiter_pkg
// Shared definitions for the keccak core arbiter: default core geometry and
// the arbiter FSM state encoding. Imported by keccak_arbiter and rr_arbiter.
// -----------------------------------------------------------------------------
package keccak_arbiter_pkg;

  localparam int RATE_DEF  = 576;  // core block width, bits
  localparam int OUT_W_DEF = 512;  // digest width, bits
  localparam int BN_W_DEF  = 10;   // byte_num width

  // One granted message walks IDLE -> CLR -> FEED -> WAIT -> DONE -> IDLE.
  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_FEED = 3'd2,
    ST_WAIT = 3'd3,
    ST_DONE = 3'd4
  } arb_state_t;

endpackage

// File: rtl/keccak_arbiter_rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick: scans the requesters starting one past the
// last granted index (wrapping) and returns the first active one.
// Ports:
//   req        in   N_REQ  active requests
//   last_grant in   IW     index granted most recently
//   pick_oh    out  N_REQ  one-hot winner (0 when no request)
//   pick_idx   out  IW     binary index of the winner
//   pick_any   out  1      at least one request active
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last_grant,
  output logic [N_REQ-1:0] pick_oh,
  output logic [IW-1:0]    pick_idx,
  output logic             pick_any
);

  logic [IW-1:0] j;

  always_comb begin
    pick_oh  = '0;
    pick_idx = '0;
    pick_any = 1'b0;
    j        = '0;
    // k = 1 first so the previous owner is considered last.
    for (int k = 1; k <= N_REQ; k++) begin
      j = IW'((int'(last_grant) + k) % N_REQ);
      if (!pick_any && req[j]) begin
        pick_any    = 1'b1;
        pick_oh[j]  = 1'b1;
        pick_idx    = j;
      end
    end
  end

endmodule

// File: rtl/keccak_arbiter.sv
// -----------------------------------------------------------------------------
// keccak_arbiter
// Shares one keccak core (rate 576, 512-bit digest) among N_REQ hash clients,
// round-robin. For each granted message the core is cleared, the owner's
// blocks are streamed into it, and the resulting digest is returned to the
// owner only.
//
// Optional feature: define KECCAK_ARB_TIMEOUT_EN to abort a message whose
// digest has not appeared TIMEOUT cycles after entering WAIT (owner gets a
// digest_err pulse, digest register unchanged). Without it WAIT is unbounded
// and digest_err is constant 0.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   req               per-requester level request (sampled only in IDLE)
//   req_in            per-requester block, slice i = [i*RATE +: RATE]
//   req_in_valid      per-requester block valid
//   req_is_last       per-requester final-block flag
//   req_byte_num      per-requester valid byte count, slice i = [i*BN_W +: BN_W]
//   req_in_ack        block accepted this cycle (owner bit only)
//   grant             one-hot owner of the core, 0 when idle
//   digest            registered digest, held until next successful DONE
//   digest_valid      one-cycle pulse to owner when digest is updated
//   digest_err        one-cycle pulse to owner on timeout abort
//   busy              FSM not in IDLE
//   core_*            connection to the keccak core
//   dbg_state         current FSM state (arb_state_t encoding)
//
// Block handshake: a block moves from the owner to the core in any FEED cycle
// where req_in_valid[owner] is high and core_buffer_full is low. In that cycle
// core_in_ready and req_in_ack[owner] are both high; the requester must hold
// its block stable until it sees the ack.
// -----------------------------------------------------------------------------
module keccak_arbiter
  import keccak_arbiter_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int RATE    = RATE_DEF,
  parameter int OUT_W   = OUT_W_DEF,
  parameter int BN_W    = BN_W_DEF,
  parameter int TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ*RATE-1:0] req_in,
  input  logic [N_REQ-1:0]      req_in_valid,
  input  logic [N_REQ-1:0]      req_is_last,
  input  logic [N_REQ*BN_W-1:0] req_byte_num,
  output logic [N_REQ-1:0]      req_in_ack,
  output logic [N_REQ-1:0]      grant,
  output logic [OUT_W-1:0]      digest,
  output logic [N_REQ-1:0]      digest_valid,
  output logic [N_REQ-1:0]      digest_err,
  output logic                  busy,
  output logic                  core_reset,
  output logic [RATE-1:0]       core_in,
  output logic                  core_in_ready,
  output logic                  core_is_last,
  output logic [BN_W-1:0]       core_byte_num,
  input  logic                  core_buffer_full,
  input  logic [OUT_W-1:0]      core_out,
  input  logic                  core_out_ready,
  output logic [2:0]            dbg_state
);

  localparam int IW = $clog2(N_REQ);

  arb_state_t      state;
  logic [IW-1:0]   owner_idx;
  logic [IW-1:0]   rr_ptr;
  logic [N_REQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            timeout_hit;

  rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_rr (
    .req        (req),
    .last_grant (rr_ptr),
    .pick_oh    (pick_oh),
    .pick_idx   (pick_idx),
    .pick_any   (pick_any)
  );

  // Owner slice mux toward the core; only meaningful while in FEED.
  assign core_in       = req_in[int'(owner_idx)*RATE +: RATE];
  assign core_byte_num = req_byte_num[int'(owner_idx)*BN_W +: BN_W];
  assign core_is_last  = req_is_last[owner_idx];

  assign core_in_ready = ~reset && (state == ST_FEED) &&
                         req_in_valid[owner_idx] && ~core_buffer_full;
  // grant is one-hot on the owner, so only the owner can ever be acked.
  assign req_in_ack    = {N_REQ{core_in_ready}} & grant;

  // Core is held in reset with the arbiter and cleared once per message.
  assign core_reset    = reset || (state == ST_CLR);
  assign dbg_state     = state;

`ifdef KECCAK_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;

  // Counts WAIT cycles; zero on the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset || state != ST_WAIT) begin
      wait_cnt <= '0;
    end else begin
      wait_cnt <= wait_cnt + TW'(1);
    end
  end

  assign timeout_hit = (state == ST_WAIT) && (wait_cnt == TW'(TIMEOUT - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      owner_idx    <= '0;
      rr_ptr       <= IW'(N_REQ - 1);  // requester 0 wins first
      grant        <= '0;
      digest       <= '0;
      digest_valid <= '0;
      digest_err   <= '0;
      busy         <= 1'b0;
    end else begin
      digest_valid <= '0;
      digest_err   <= '0;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            owner_idx <= pick_idx;
            grant     <= pick_oh;
            busy      <= 1'b1;
            state     <= ST_CLR;
          end
        end
        ST_CLR: begin
          state <= ST_FEED;
        end
        ST_FEED: begin
          if (core_in_ready && core_is_last) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // A digest arriving on the timeout cycle still counts as success.
          if (core_out_ready) begin
            digest       <= core_out;
            digest_valid <= grant;
            state        <= ST_DONE;
          end else if (timeout_hit) begin
            digest_err <= grant;
            state      <= ST_DONE;
          end
        end
        ST_DONE: begin
          rr_ptr <= owner_idx;
          grant  <= '0;
          busy   <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
